// File: rtl/sprite_pkg.sv
// Shared sprite image constants and the tile writer state type.
// Imported by both the sprite renderer and the tile writer.
package sprite_pkg;

  localparam int SPRITE_WIDTH    = 16;
  localparam int TILE_HEIGHT     = 16;
  localparam int TILE_PIXELS     = SPRITE_WIDTH * TILE_HEIGHT;
  localparam int NUM_TILES       = 37;
  localparam int IMAGE_RAM_DEPTH = NUM_TILES * TILE_PIXELS;
  localparam int IMAGE_ADDR_W    = $clog2(IMAGE_RAM_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } tile_wr_state_t;

endpackage

// File: rtl/tile_addr_counter.sv
// Column/row position counter for a tile walk.
// It raises a last flag at the bottom-right pixel.
module tile_addr_counter #(
  parameter int COL_W = 4,
  parameter int ROW_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      col <= col + 1'b1;
      if (&col) row <= row + 1'b1;
    end
  end

  assign last = (&col) & (&row);

endmodule

// File: rtl/sprite_tile_writer.sv
// Streams one tile of palette indices into the sprite image RAM write port.
// The tile layout is tile_index*pixels_per_tile + row*WIDTH + col.
module sprite_tile_writer #(
  parameter int WIDTH       = 16,
  parameter int TILE_HEIGHT = 16,
  parameter int NUM_TILES   = 37,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                                              pixel_clk_in,
  input  logic                                              rst_in,
  input  logic                                              start_in,
  input  logic [5:0]                                        tile_index_in,
  input  logic                                              pixel_valid_in,
  input  logic [DATA_WIDTH-1:0]                             pixel_data_in,
  output logic                                              pixel_ready_out,
  output logic [$clog2(NUM_TILES*WIDTH*TILE_HEIGHT)-1:0]    ram_addr_out,
  output logic [DATA_WIDTH-1:0]                             ram_data_out,
  output logic                                              ram_we_out,
  output logic                                              busy_out,
  output logic                                              done_out,
  output logic                                              error_out
);

  import sprite_pkg::*;

  localparam int ADDR_W    = $clog2(NUM_TILES * WIDTH * TILE_HEIGHT);
  localparam int COL_W     = $clog2(WIDTH);
  localparam int ROW_W     = $clog2(TILE_HEIGHT);
  localparam int PIX_SHIFT = COL_W + ROW_W;

  tile_wr_state_t    state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              last;
  logic              handshake;
  logic              tile_ok;
  logic              start_ok;
  logic [ADDR_W-1:0] pixel_addr;

  assign tile_ok   = 32'(tile_index_in) < NUM_TILES;
  assign start_ok  = (state_q == IDLE) && start_in && tile_ok;
  assign handshake = pixel_valid_in & pixel_ready_out;

  // Power-of-two geometry makes row*WIDTH + col a plain concatenation.
  assign pixel_addr = base_q + ADDR_W'({row, col});

  tile_addr_counter #(
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_counter (
    .clk    (pixel_clk_in),
    .rst    (rst_in),
    .clear  (state_q != LOAD),
    .advance(handshake),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d         = state_q;
    pixel_ready_out = 1'b0;
    busy_out        = 1'b0;
    done_out        = 1'b0;
    unique case (state_q)
      IDLE: if (start_ok) state_d = LOAD;
      LOAD: begin
        pixel_ready_out = 1'b1;
        busy_out        = 1'b1;
        if (handshake && last) state_d = DONE;
      end
      DONE: begin
        busy_out = 1'b1;
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      base_q       <= '0;
      ram_addr_out <= '0;
      ram_data_out <= '0;
      ram_we_out   <= 1'b0;
      error_out    <= 1'b0;
    end else begin
      ram_we_out <= handshake;
      error_out  <= (state_q == IDLE) && start_in && !tile_ok;
      if (start_ok) base_q <= ADDR_W'(tile_index_in) << PIX_SHIFT;
      if (handshake) begin
        ram_addr_out <= pixel_addr;
        ram_data_out <= pixel_data_in;
      end
    end
  end

endmodule

// File: doc/sprite_tile_writer.md
# sprite_tile_writer

Loads one 16x16 tile of 8-bit palette indices into the sprite image RAM from a valid/ready byte stream. Sits on the write port (port B) of the dual-port image RAM, opposite the sprite renderer's read port. Tile layout matches the renderer exactly: address = tile_index*256 + row*16 + col. Used at boot or on command to replace sprite art without re-synthesis.

## Interface

- WIDTH, 16, tile width in pixels (power of two)
- TILE_HEIGHT, 16, tile height in rows (power of two)
- NUM_TILES, 37, tiles held in RAM (37*256 = 9472 entries)
- DATA_WIDTH, 8, palette index width

- pixel_clk_in  input  1  clock; all logic on rising edge
- rst_in  input  1  reset, synchronous, active-high
- start_in  input  1  request a tile load; sampled only in IDLE
- tile_index_in  input  6  target tile; sampled with start_in
- pixel_valid_in  input  1  pixel_data_in valid
- pixel_data_in  input  DATA_WIDTH  palette index, row-major, col 0 first
- pixel_ready_out  output  1  writer accepts a pixel this cycle
- ram_addr_out  output  $clog2(NUM_TILES*WIDTH*TILE_HEIGHT) (14)  RAM write address
- ram_data_out  output  DATA_WIDTH  RAM write data
- ram_we_out  output  1  RAM write enable
- busy_out  output  1  high in LOAD and DONE
- done_out  output  1  one-cycle pulse, tile complete
- error_out  output  1  one-cycle pulse, start rejected (tile_index_in >= NUM_TILES)

## Operation

- States: IDLE, LOAD, DONE.
- IDLE: pixel_ready_out=0. start_in=1 and tile_index_in < NUM_TILES -> latch base = tile_index_in*WIDTH*TILE_HEIGHT, col=0, row=0, go LOAD. start_in=1 with tile_index_in >= NUM_TILES -> error_out=1 next cycle, stay IDLE.
- LOAD: pixel_ready_out=1 (combinational from state). Handshake = pixel_valid_in & pixel_ready_out. Each handshake registers a write: ram_addr_out = base + row*WIDTH + col, ram_data_out = pixel_data_in, ram_we_out=1, all in the following cycle. col increments; col wraps WIDTH-1 -> 0 and row increments. Valid low -> no write, counters hold, no timeout.
- Handshake at row=TILE_HEIGHT-1, col=WIDTH-1 (256th pixel) -> DONE.
- DONE: one cycle; pixel_ready_out=0, done_out=1, then IDLE.
- start_in ignored outside IDLE; tile_index_in changes during LOAD have no effect.
- Arithmetic: base computed 14-bit unsigned; row*WIDTH and base sum are shifts/adds with no overflow (max address 9471). Counters are $clog2(WIDTH) and $clog2(TILE_HEIGHT) bits.
- Reset (any state, incl. mid-tile): state IDLE, counters 0, all outputs 0 next cycle; partially written tile left as-is, no further writes.

## Timing

- Reset values: pixel_ready_out=0, ram_we_out=0, ram_addr_out=0, ram_data_out=0, busy_out=0, done_out=0, error_out=0.
- start at cycle T -> LOAD at T+1, pixel_ready_out=1 at T+1.
- Handshake at cycle N -> ram_we_out/addr/data valid during N+1 (1-cycle latency); ram_we_out=0 in any cycle not following a handshake.
- Last handshake at N -> DONE during N+1: done_out=1 coinciding with the final write; IDLE at N+2, earliest next start sampled at N+2.
- Full-rate stream: 256 pixels in 256 consecutive cycles; one tile load = 258 cycles start-to-IDLE.
- error_out asserted exactly one cycle after rejected start; busy_out stays 0.

## Structure

- Shared package sprite_pkg: SPRITE_WIDTH=16, TILE_HEIGHT=16, TILE_PIXELS=256, NUM_TILES=37, IMAGE_RAM_DEPTH=9472, IMAGE_ADDR_W=14, typedef enum {IDLE, LOAD, DONE} tile_wr_state_t. Renderer and writer both import it.
- One sub-module: tile_addr_counter (col/row counter with advance, clear, last flag); FSM and output registers in top.

## Test plan

- Reset then start_in=1, tile_index_in=0, 256 pixels data=i at full rate -> writes addr 0..255 data 0..255 on consecutive cycles; done_out pulses with addr 255 write; busy_out low afterward.
- tile_index_in=36, valid toggling 1/0 every cycle -> 256 writes at addr 9216..9471, no write in gap cycles, done_out once.
- tile_index_in=37 -> error_out one cycle, no ram_we_out, busy_out=0, pixel_ready_out=0.
- start_in held high during LOAD with tile_index_in=5 after starting tile 2 -> all writes stay in 512..767; no restart.
- rst_in after 100 pixels of tile 3 -> next cycle all outputs 0, state IDLE; new start tile 3 rewrites from addr 768.
- Back-to-back: start asserted again the cycle after done_out -> accepted, second tile begins at expected base, no dropped or duplicated pixel.
